// File: rtl/dct_transpose_pingpong.sv
// Ping-pong 8x8 transpose buffer between the row-pass and column-pass DCT.
// Rows are written into one bank while the other bank drains column by column.
// Data is stored and returned bit-exact; no arithmetic is performed.
module dct_transpose_pingpong #(
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in0,
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   input  logic [DATA_W-1:0] in3,
   input  logic [DATA_W-1:0] in4,
   input  logic [DATA_W-1:0] in5,
   input  logic [DATA_W-1:0] in6,
   input  logic [DATA_W-1:0] in7,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out0,
   output logic [DATA_W-1:0] out1,
   output logic [DATA_W-1:0] out2,
   output logic [DATA_W-1:0] out3,
   output logic [DATA_W-1:0] out4,
   output logic [DATA_W-1:0] out5,
   output logic [DATA_W-1:0] out6,
   output logic [DATA_W-1:0] out7,
   output logic [2:0]        out_col,
   output logic              out_last
);

   localparam int unsigned N        = 8;
   localparam int unsigned IDX_W    = 3;
   localparam int unsigned BANKS    = 2;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   // Each bank holds N rows; each row is a packed vector of N coefficients.
   logic [N-1:0][DATA_W-1:0] mem [BANKS][N];

   logic             wr_bank;
   logic [IDX_W-1:0] wr_row;
   logic             rd_bank;
   logic [IDX_W-1:0] rd_col;
   logic [BANKS-1:0] full;
   logic [BANKS-1:0] full_nxt;

   logic             wr_fire;
   logic             rd_fire;
   logic [N-1:0][DATA_W-1:0] in_row;
   logic [N-1:0][DATA_W-1:0] out_vec;

   // Gather the incoming row elements, column index 0..7.
   assign in_row[0] = in0;
   assign in_row[1] = in1;
   assign in_row[2] = in2;
   assign in_row[3] = in3;
   assign in_row[4] = in4;
   assign in_row[5] = in5;
   assign in_row[6] = in6;
   assign in_row[7] = in7;

   // Handshakes depend on bank occupancy only, never on the opposite side's strobe.
   always_comb begin
      in_ready  = !full[wr_bank];
      out_valid = full[rd_bank];
      wr_fire   = in_valid && in_ready;
      rd_fire   = out_valid && out_ready;
   end

   // Bank occupancy update; a write and a read in the same cycle never share a bank.
   always_comb begin
      full_nxt = full;
      if (rd_fire && (rd_col == LAST_IDX)) begin
         full_nxt[rd_bank] = 1'b0;
      end
      if (wr_fire && (wr_row == LAST_IDX)) begin
         full_nxt[wr_bank] = 1'b1;
      end
   end

   // Write/read pointers and occupancy flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank <= 1'b0;
         wr_row  <= '0;
         rd_bank <= 1'b0;
         rd_col  <= '0;
         full    <= '0;
      end else begin
         full <= full_nxt;
         if (wr_fire) begin
            wr_row <= wr_row + IDX_W'(1);
            if (wr_row == LAST_IDX) begin
               wr_bank <= ~wr_bank;
            end
         end
         if (rd_fire) begin
            rd_col <= rd_col + IDX_W'(1);
            if (rd_col == LAST_IDX) begin
               rd_bank <= ~rd_bank;
            end
         end
      end
   end

   // Row storage; contents are deliberately left uncleared by reset.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wr_bank][wr_row] <= in_row;
      end
   end

   // Column read: element k of the output vector is row k of the draining bank.
   for (genvar k = 0; k < N; k++) begin : g_col_read
      assign out_vec[k] = out_valid ? mem[rd_bank][k][rd_col] : '0;
   end

   assign out0     = out_vec[0];
   assign out1     = out_vec[1];
   assign out2     = out_vec[2];
   assign out3     = out_vec[3];
   assign out4     = out_vec[4];
   assign out5     = out_vec[5];
   assign out6     = out_vec[6];
   assign out7     = out_vec[7];
   assign out_col  = rd_col;
   assign out_last = out_valid && (rd_col == LAST_IDX);

endmodule

// File: tb/tb_dct_transpose_pingpong.sv
// Directed bench for the ping-pong transpose buffer.
module tb_dct_transpose_pingpong;

   localparam int unsigned DATA_W = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic              out_valid;
   logic              out_ready;
   logic [2:0]        out_col;
   logic              out_last;
   logic [DATA_W-1:0] in_v [8];
   logic [DATA_W-1:0] outs [8];

   int n_tests = 0;
   int n_fail  = 0;

   dct_transpose_pingpong #(.DATA_W(DATA_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in0      (in_v[0]),
      .in1      (in_v[1]),
      .in2      (in_v[2]),
      .in3      (in_v[3]),
      .in4      (in_v[4]),
      .in5      (in_v[5]),
      .in6      (in_v[6]),
      .in7      (in_v[7]),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out0     (outs[0]),
      .out1     (outs[1]),
      .out2     (outs[2]),
      .out3     (outs[3]),
      .out4     (outs[4]),
      .out5     (outs[5]),
      .out6     (outs[6]),
      .out7     (outs[7]),
      .out_col  (out_col),
      .out_last (out_last)
   );

   always #5 clk = ~clk;

   // Element (r, c) of a block whose values start at base.
   function automatic logic [DATA_W-1:0] pat(input int base, input int r, input int c);
      return DATA_W'(base + 16 * r + c);
   endfunction

   // Advance one edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_row(input int base, input int r);
      for (int c = 0; c < 8; c++) in_v[c] = pat(base, r, c);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      for (int c = 0; c < 8; c++) in_v[c] = '0;
      step(); step();
      rst = 1'b0;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_tests++; if (out_col !== 3'd0) begin n_fail++; $display("FAIL reset_out_col got %0d want 0", out_col); end
      n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b want 0", out_last); end
      for (int k = 0; k < 8; k++) begin
         n_tests++; if (outs[k] !== '0) begin n_fail++; $display("FAIL reset_out%0d got %h want 0", k, outs[k]); end
      end
   endtask

   task automatic test_single_block();
      out_ready = 1'b1;
      for (int r = 0; r < 8; r++) begin
         load_row(0, r); in_valid = 1'b1;
         n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL t1_in_ready row %0d got %b want 1", r, in_ready); end
         n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL t1_early_valid row %0d got %b want 0", r, out_valid); end
         step();
      end
      in_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
         n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL t1_out_valid col %0d got %b want 1", c, out_valid); end
         n_tests++; if (out_col !== 3'(c)) begin n_fail++; $display("FAIL t1_out_col got %0d want %0d", out_col, c); end
         n_tests++; if (out_last !== (c == 7)) begin n_fail++; $display("FAIL t1_out_last col %0d got %b want %b", c, out_last, (c == 7)); end
         for (int k = 0; k < 8; k++) begin
            n_tests++; if (outs[k] !== pat(0, k, c)) begin n_fail++; $display("FAIL t1_data col %0d out%0d got %h want %h", c, k, outs[k], pat(0, k, c)); end
         end
         step();
      end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL t1_drained got %b want 0", out_valid); end
      n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL t1_last_after got %b want 0", out_last); end
   endtask

   task automatic test_back_to_back();
      int row = 0;
      int col = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (row < 24) begin
            load_row(256 * (row / 8), row % 8); in_valid = 1'b1;
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL t2_in_ready cyc %0d got %b want 1", cyc, in_ready); end
         end else begin
            in_valid = 1'b0;
         end
         if (out_valid === 1'b1) begin
            if (col >= 24) begin
               n_tests++; n_fail++; $display("FAIL t2_extra_column cyc %0d got col %0d want none", cyc, out_col);
            end else begin
               n_tests++; if (out_col !== 3'(col % 8)) begin n_fail++; $display("FAIL t2_out_col got %0d want %0d", out_col, col % 8); end
               n_tests++; if (out_last !== (col % 8 == 7)) begin n_fail++; $display("FAIL t2_out_last col %0d got %b", col, out_last); end
               for (int k = 0; k < 8; k++) begin
                  n_tests++; if (outs[k] !== pat(256 * (col / 8), k, col % 8)) begin n_fail++; $display("FAIL t2_data col %0d out%0d got %h want %h", col, k, outs[k], pat(256 * (col / 8), k, col % 8)); end
               end
            end
            col++;
         end
         if (in_valid && in_ready) row++;
         step();
      end
      in_valid = 1'b0;
      n_tests++; if (col != 24) begin n_fail++; $display("FAIL t2_column_count got %0d want 24", col); end
   endtask

   task automatic test_stall_full();
      out_ready = 1'b0;
      for (int r = 0; r < 16; r++) begin
         load_row(256 * (r / 8), r % 8); in_valid = 1'b1;
         n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL t3_in_ready row %0d got %b want 1", r, in_ready); end
         step();
      end
      for (int c = 0; c < 8; c++) in_v[c] = 16'h7777;
      for (int i = 0; i < 3; i++) begin
         n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL t3_full_in_ready cyc %0d got %b want 0", i, in_ready); end
         n_tests++; if (out_col !== 3'd0) begin n_fail++; $display("FAIL t3_stall_col got %0d want 0", out_col); end
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int col = 0; col < 16; col++) begin
         n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL t3_out_valid col %0d got %b want 1", col, out_valid); end
         n_tests++; if (in_ready !== (col >= 8)) begin n_fail++; $display("FAIL t3_in_ready_return col %0d got %b want %b", col, in_ready, (col >= 8)); end
         n_tests++; if (out_col !== 3'(col % 8)) begin n_fail++; $display("FAIL t3_out_col got %0d want %0d", out_col, col % 8); end
         for (int k = 0; k < 8; k++) begin
            n_tests++; if (outs[k] !== pat(256 * (col / 8), k, col % 8)) begin n_fail++; $display("FAIL t3_data col %0d out%0d got %h want %h", col, k, outs[k], pat(256 * (col / 8), k, col % 8)); end
         end
         step();
      end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL t3_drained got %b want 0", out_valid); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL t3_ready_end got %b want 1", in_ready); end
   endtask

   task automatic test_random_ready();
      int col = 0;
      int cyc = 0;
      logic have_prev = 1'b0;
      logic [2:0] prev_col = '0;
      logic [DATA_W-1:0] prev_outs [8];
      out_ready = 1'b0;
      for (int r = 0; r < 8; r++) begin
         load_row(768, r); in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      while (cyc < 200 && col < 8) begin
         out_ready = 1'($urandom_range(0, 1));
         n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL t4_out_valid cyc %0d got %b want 1", cyc, out_valid); end
         if (have_prev) begin
            n_tests++; if (out_col !== prev_col) begin n_fail++; $display("FAIL t4_hold_col got %0d want %0d", out_col, prev_col); end
            for (int k = 0; k < 8; k++) begin
               n_tests++; if (outs[k] !== prev_outs[k]) begin n_fail++; $display("FAIL t4_hold out%0d got %h want %h", k, outs[k], prev_outs[k]); end
            end
         end
         n_tests++; if (out_col !== 3'(col)) begin n_fail++; $display("FAIL t4_out_col got %0d want %0d", out_col, col); end
         for (int k = 0; k < 8; k++) begin
            n_tests++; if (outs[k] !== pat(768, k, col)) begin n_fail++; $display("FAIL t4_data col %0d out%0d got %h want %h", col, k, outs[k], pat(768, k, col)); end
         end
         have_prev = !out_ready;
         prev_col  = out_col;
         for (int k = 0; k < 8; k++) prev_outs[k] = outs[k];
         if (out_ready) col++;
         cyc++;
         step();
      end
      out_ready = 1'b1;
      n_tests++; if (col != 8) begin n_fail++; $display("FAIL t4_timeout got %0d columns want 8", col); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL t4_drained got %b want 0", out_valid); end
   endtask

   task automatic test_reset_mid_block();
      out_ready = 1'b1;
      for (int r = 0; r < 5; r++) begin
         load_row(1280, r); in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL t5_in_ready got %b want 1", in_ready); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL t5_out_valid got %b want 0", out_valid); end
      n_tests++; if (out_col !== 3'd0) begin n_fail++; $display("FAIL t5_out_col got %0d want 0", out_col); end
      n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL t5_out_last got %b want 0", out_last); end
      for (int k = 0; k < 8; k++) begin
         n_tests++; if (outs[k] !== '0) begin n_fail++; $display("FAIL t5_zero out%0d got %h want 0", k, outs[k]); end
      end
      for (int r = 0; r < 8; r++) begin
         load_row(1536, r); in_valid = 1'b1;
         n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL t5_early_valid row %0d got %b want 0", r, out_valid); end
         step();
      end
      in_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
         n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL t5_out_valid col %0d got %b want 1", c, out_valid); end
         for (int k = 0; k < 8; k++) begin
            n_tests++; if (outs[k] !== pat(1536, k, c)) begin n_fail++; $display("FAIL t5_data col %0d out%0d got %h want %h", c, k, outs[k], pat(1536, k, c)); end
         end
         step();
      end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL t5_drained got %b want 0", out_valid); end
   endtask

   task automatic test_negative();
      logic [DATA_W-1:0] want;
      out_ready = 1'b1;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) in_v[c] = DATA_W'(-(r + 1));
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
         n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL t6_out_valid col %0d got %b want 1", c, out_valid); end
         for (int k = 0; k < 8; k++) begin
            want = DATA_W'(-(k + 1));
            n_tests++; if (outs[k] !== want) begin n_fail++; $display("FAIL t6_neg col %0d out%0d got %h want %h", c, k, outs[k], want); end
         end
         step();
      end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL t6_drained got %b want 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_single_block();
      test_back_to_back();
      test_stall_full();
      test_random_ready();
      test_reset_mid_block();
      test_negative();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
